// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one mem_system port; req_i->done_o in 2 cycles minimum, WAIT aborts after TIMEOUT cycles.
// Requesters hold req_i until their done_o pulse; one access is in flight at a time and all others wait in IDLE arbitration.
module mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          done_o,
  output logic [NUM_REQ-1:0]          err_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        hit_o,
  output logic                        mem_req,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic                        mem_done,
  input  logic [DATA_W-1:0]           mem_data_out,
  input  logic                        mem_hit,
  output logic                        busy_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_o
);

  localparam int GRANT_W = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t             state, state_nxt;
  logic [GRANT_W-1:0] ptr;
  logic [GRANT_W-1:0] sel_idx;
  logic               sel_vld;
  req_t               sel_req;
  req_t               lat;
  logic [CNT_W-1:0]   wait_cnt;
  logic               err_q;
  logic               load, capture, timeout, cnt_clr, cnt_inc;

  function automatic logic [GRANT_W-1:0] wrap_idx(input logic [GRANT_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return GRANT_W'(s);
  endfunction

  // Walk offsets from the far end so the nearest requester after ptr is the final winner.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[wrap_idx(ptr, i)]) begin
        sel_vld = 1'b1;
        sel_idx = wrap_idx(ptr, i);
      end
    end
  end

  always_comb begin
    sel_req.wr    = wr_i[sel_idx];
    sel_req.addr  = addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
    sel_req.wdata = wdata_i[int'(sel_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clr = 1'b1;
        if (mem_done) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response on the final allowed WAIT cycle still wins over the abort.
        if (mem_done) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt >= CNT_W'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= GRANT_W'(NUM_REQ - 1);
      grant_o  <= '0;
      lat      <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      rdata_o  <= '0;
      hit_o    <= 1'b0;
    end else begin
      if (load) begin
        ptr     <= sel_idx;
        grant_o <= sel_idx;
        lat     <= sel_req;
      end
      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (capture) begin
        rdata_o <= mem_data_out;
        hit_o   <= mem_hit;
      end else if (timeout) begin
        rdata_o <= '0;
        hit_o   <= 1'b0;
      end
      if (capture || timeout) err_q <= timeout;
    end
  end

  always_comb begin
    mem_req     = (state == ISSUE);
    mem_wr      = lat.wr;
    mem_addr    = lat.addr;
    mem_data_in = lat.wdata;
    busy_o      = (state != IDLE);
    done_o      = (state == DONE) ? (NUM_REQ'(1) << grant_o) : '0;
    err_o       = err_q ? done_o : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, every cycle compared against a
// timestamp-based transaction model (issue cycle, completion cycle, owner, latched request, response).
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int GW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_i, wr_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]    done_o, err_o;
  logic [DW-1:0]   rdata_o;
  logic            hit_o;
  logic            mem_req, mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_in;
  logic            mem_done;
  logic [DW-1:0]   mem_data_out;
  logic            mem_hit;
  logic            busy_o;
  logic [GW-1:0]   grant_o;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .hit_o(hit_o),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_done(mem_done), .mem_data_out(mem_data_out), .mem_hit(mem_hit),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  int n_chk, n_err, cyc, c0;

  // reference model: one transaction described by its timestamps
  bit            m_act, m_err;
  int            t_iss, t_done, m_d, m_g, m_last;
  logic [AW-1:0] m_addr;
  logic          m_wr, m_hit_t, m_hit;
  logic [DW-1:0] m_wd, m_rd_t, m_rdata;
  logic [GW-1:0] m_gr;
  int            drop_cyc[N];

  // stimulus knobs and observed-event log
  bit            rand_req, rand_mem, reraise, fix_dat_en;
  int            fix_delay;
  logic [DW-1:0] fix_dat;
  logic          fix_hit;
  int            dut_glog[$];
  int            last_mreq_cyc, last_done_cyc;
  logic [N-1:0]  last_done, last_err;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_act   = 1'b0;
    m_gr    = '0;
    m_addr  = '0;
    m_wr    = 1'b0;
    m_wd    = '0;
    m_rdata = '0;
    m_hit   = 1'b0;
    m_last  = N - 1;
  endtask

  task automatic raise(input int i);
    req_i[i]            = 1'b1;
    wr_i[i]             = 1'($urandom_range(1));
    addr_i[i*AW +: AW]  = $urandom();
    wdata_i[i*DW +: DW] = $urandom();
  endtask

  // Advance one cycle, compare every output, then drive this cycle's default stimulus.
  task automatic tick();
    bit busy_e, is_done;
    @(posedge clk);
    #1;
    cyc++;
    busy_e  = m_act && cyc >= t_iss && cyc <= t_done;
    is_done = m_act && cyc == t_done;
    if (is_done) begin
      m_rdata = m_err ? '0 : m_rd_t;
      m_hit   = m_err ? 1'b0 : m_hit_t;
    end
    check_val("busy_o", busy_o, busy_e);
    check_val("mem_req", mem_req, m_act && cyc == t_iss);
    check_val("done_o", done_o, is_done ? (N'(1) << m_g) : '0);
    check_val("err_o", err_o, (is_done && m_err) ? (N'(1) << m_g) : '0);
    check_val("rdata_o", rdata_o, m_rdata);
    check_val("hit_o", hit_o, m_hit);
    check_val("grant_o", grant_o, m_gr);
    check_val("mem_addr", mem_addr, m_addr);
    check_val("mem_wr", mem_wr, m_wr);
    check_val("mem_data_in", mem_data_in, m_wd);
    check_val("done_onehot", $countones(done_o) <= 1, 1);
    if (mem_req) last_mreq_cyc = cyc;
    if (done_o != '0) begin
      last_done_cyc = cyc;
      last_done     = done_o;
      last_err      = err_o;
      dut_glog.push_back(int'(grant_o));
    end

    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (is_done && m_g == i) begin
        req_i[i]    = 1'b0;
        drop_cyc[i] = cyc;
      end else if (!req_i[i] && cyc >= drop_cyc[i] + 2 &&
                   (reraise || (rand_req && $urandom_range(3) == 0))) begin
        raise(i);
      end else if (rand_req && req_i[i] && busy_e && m_g == i) begin
        if ($urandom_range(7) == 0) begin
          addr_i[i*AW +: AW]  = $urandom();
          wdata_i[i*DW +: DW] = $urandom();
          wr_i[i]             = ~wr_i[i];
        end
        if ($urandom_range(15) == 0) begin
          req_i[i]    = 1'b0;
          drop_cyc[i] = cyc;
        end
      end
    end

    mem_data_out = fix_dat_en ? fix_dat : $urandom();
    mem_hit      = fix_dat_en ? fix_hit : 1'($urandom_range(1));
    mem_done     = 1'b0;
    if (busy_e && !m_err && cyc == t_iss + m_d) begin
      mem_done = 1'b1;
      m_rd_t   = mem_data_out;
      m_hit_t  = mem_hit;
    end else if (!(busy_e && cyc < t_done) && rand_mem && $urandom_range(3) == 0) begin
      mem_done = 1'b1;
    end
  endtask

  // Apply the rules to the inputs finally driven in this cycle.
  task automatic commit();
    if (rst) begin
      model_reset();
    end else if (!(m_act && cyc >= t_iss && cyc <= t_done) && req_i != '0) begin
      int g;
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (g < 0 && req_i[idx]) g = idx;
      end
      m_g    = g;
      m_last = g;
      m_gr   = GW'(g);
      m_addr = addr_i[g*AW +: AW];
      m_wr   = wr_i[g];
      m_wd   = wdata_i[g*DW +: DW];
      t_iss  = cyc + 1;
      m_d    = (fix_delay >= 0) ? fix_delay : int'($urandom_range(TO + 3, 0));
      m_err  = (m_d > TO);
      t_done = m_err ? t_iss + TO + 1 : t_iss + m_d + 1;
      m_act  = 1'b1;
    end
  endtask

  task automatic step();
    tick();
    commit();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    model_reset();
    for (int i = 0; i < N; i++) drop_cyc[i] = -10;
    rand_req = 0; rand_mem = 0; reraise = 0; fix_dat_en = 0; fix_delay = -1;
    fix_dat = '0; fix_hit = 1'b0;
    last_mreq_cyc = -1; last_done_cyc = -1; last_done = '0; last_err = '0;
    rst = 1'b1; req_i = '0; wr_i = '0; addr_i = '0; wdata_i = '0;
    mem_done = 1'b0; mem_data_out = '0; mem_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy_o, 0);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_rdata", rdata_o, 0);
    check_val("rst_grant", grant_o, 0);
    rst = 1'b0;
    commit();

    // single read from requester 1
    fix_delay = 3; fix_dat_en = 1; fix_dat = 32'hDEAD_BEEF; fix_hit = 1'b1;
    tick();
    req_i = 3'b010; wr_i[1] = 1'b0; addr_i[1*AW +: AW] = 32'h0000_6004;
    c0 = cyc;
    commit();
    repeat (8) step();
    check_val("rd_mreq_cycle", last_mreq_cyc, c0 + 1);
    check_val("rd_done_cycle", last_done_cyc, c0 + 5);
    check_val("rd_done_bits", last_done, 3'b010);
    check_val("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    check_val("rd_hit", hit_o, 1);

    // contention from reset: all requesters held and re-raised
    fix_delay = 1; fix_dat_en = 0;
    tick(); rst = 1'b1; commit();
    tick();
    for (int i = 0; i < N; i++) raise(i);
    dut_glog.delete();
    reraise = 1;
    commit();
    for (int k = 0; k < 60 && dut_glog.size() < 6; k++) step();
    reraise = 0;
    check_val("cont_count", dut_glog.size(), 6);
    for (int k = 0; k < 6; k++)
      check_val($sformatf("cont_grant%0d", k), (k < dut_glog.size()) ? dut_glog[k] : -1, k % 3);
    repeat (40) step();

    // timeout: write that never completes
    fix_delay = 1000;
    tick();
    req_i = 3'b100; wr_i[2] = 1'b1; addr_i[2*AW +: AW] = 32'h0000_0040; wdata_i[2*DW +: DW] = $urandom();
    c0 = cyc;
    commit();
    repeat (14) step();
    check_val("to_done_cycle", last_done_cyc, c0 + 10);
    check_val("to_err_bits", last_err, 3'b100);
    check_val("to_rdata", rdata_o, 0);
    check_val("to_idle", busy_o, 0);

    // inputs change and req drops while waiting
    fix_delay = 5;
    tick();
    req_i = 3'b001; wr_i[0] = 1'b0; addr_i[0 +: AW] = 32'h0000_1230; wdata_i[0 +: DW] = $urandom();
    c0 = cyc;
    commit();
    step();
    tick();
    addr_i[0 +: AW] = 32'h0000_FFFC; req_i[0] = 1'b0;
    commit();
    repeat (8) step();
    check_val("stab_done_cycle", last_done_cyc, c0 + 7);
    check_val("stab_done_bits", last_done, 3'b001);
    check_val("stab_addr", mem_addr, 32'h0000_1230);
    check_val("stab_no_regrant", last_mreq_cyc, c0 + 1);

    // reset in the middle of WAIT, then a late response
    fix_delay = 1000;
    tick(); raise(1); commit();
    c0 = cyc;
    step();
    step();
    tick(); rst = 1'b1; req_i = '0; commit();
    tick();
    check_val("mid_rst_busy", busy_o, 0);
    check_val("mid_rst_mem_req", mem_req, 0);
    mem_done = 1'b1;
    commit();
    tick();
    check_val("late_done_busy", busy_o, 0);
    check_val("late_done_done", done_o, 0);
    fix_delay = 2;
    for (int i = 0; i < N; i++) raise(i);
    commit();
    tick();
    check_val("post_rst_grant", grant_o, 0);
    check_val("post_rst_issue", mem_req, 1);
    commit();
    repeat (40) step();

    // randomized traffic with stray responses and occasional resets
    fix_delay = -1; rand_req = 1; rand_mem = 1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(199) == 0) rst = 1'b1;
      commit();
    end
    rand_req = 0; rand_mem = 0;
    repeat (60) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters sharing one mem_system port (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum WAIT cycles before abort.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port req_i  in  NUM_REQ  per-requester request, held high until done_o.
REQ-009 SHALL have port wr_i  in  NUM_REQ  per-requester write(1)/read(0).
REQ-010 SHALL have port addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester n at [n*ADDR_W +: ADDR_W].
REQ-011 SHALL have port wdata_i  in  NUM_REQ*DATA_W  packed write data.
REQ-012 SHALL have port done_o  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-013 SHALL have port err_o  out  NUM_REQ  one-cycle timeout flag, coincident with done_o.
REQ-014 SHALL have port rdata_o  out  DATA_W  read data, valid while done_o is high.
REQ-015 SHALL have port hit_o  out  1  cache-hit status of the completed access, valid with done_o.
REQ-016 SHALL have ports mem_req/mem_wr (out, 1), mem_addr (out, ADDR_W), mem_data_in (out, DATA_W): the mem_system request side.
REQ-017 SHALL have ports mem_done (in, 1), mem_data_out (in, DATA_W), mem_hit (in, 1): the mem_system response side.
REQ-018 SHALL have ports busy_o  out  1  (state != IDLE) and grant_o  out  $clog2(NUM_REQ)  current owner.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 In IDLE with any req_i high, SHALL select the first requester at or after ptr+1 (mod NUM_REQ), latch its wr/addr/wdata into internal registers, set grant_o and ptr to it, and go to ISSUE.
REQ-021 In ISSUE, SHALL assert mem_req for exactly one cycle and go to WAIT; mem_wr/mem_addr/mem_data_in SHALL come from the latched registers and stay stable from ISSUE through DONE.
REQ-022 SHALL sample mem_done in ISSUE and WAIT; on mem_done it SHALL capture mem_data_out into rdata_o and mem_hit into hit_o, then go to DONE.
REQ-023 In DONE, SHALL pulse done_o[grant_o] for one cycle and return to IDLE; min latency is req_i at cycle 0 -> done_o at cycle 2, IDLE at cycle 3.
REQ-024 A requester SHALL drop req_i in the cycle after done_o; the arbiter SHALL make no other provision against re-grant.
REQ-025 A WAIT cycle counter SHALL saturate-compare to TIMEOUT; on reaching it without mem_done, SHALL go to DONE with err_o[grant_o]=1, rdata_o=0, hit_o=0.
REQ-026 A req_i deassert, or changes to addr_i/wr_i/wdata_i, during ISSUE/WAIT SHALL be ignored; the transaction completes and done_o still pulses.
REQ-027 mem_done while in IDLE or DONE SHALL be ignored.
REQ-028 rdata_o and hit_o SHALL hold their values until the next capture.
REQ-029 All outputs other than rdata_o/hit_o SHALL be registered or decoded from state only, with no combinational path from req_i.

Reset
REQ-030 On rst SHALL force state=IDLE, ptr=NUM_REQ-1 (requester 0 highest priority first), counter=0, mem_req=0, done_o=0, err_o=0, rdata_o=0, hit_o=0, grant_o=0, busy_o=0, latched registers=0.
REQ-031 rst in any state SHALL abandon the in-flight access with no done_o pulse; mem_system is reset concurrently.

Verification
REQ-032 Single read: req_i=3'b010, addr 0x6004, mem_done 3 cycles after mem_req with mem_data_out=0xDEADBEEF, mem_hit=1 -> mem_req high only at cycle 1 with mem_addr 0x6004, mem_wr=0; done_o=3'b010 one cycle later; rdata_o=0xDEADBEEF, hit_o=1.
REQ-033 Contention: req_i=3'b111 held, each requester re-raised after its done, mem_done 1 cycle after mem_req -> grant order 0,1,2,0,1,2; never two done_o bits high.
REQ-034 Timeout: TIMEOUT=8, write to 0x0040 with mem_done never asserted -> done_o and err_o bit set 8 WAIT cycles after ISSUE, rdata_o=0, state back to IDLE.
REQ-035 Stability: during WAIT change addr_i to 0xFFFC and drop req_i -> mem_addr stays at the original value; done_o still pulses; no re-grant.
REQ-036 Reset mid-WAIT: assert rst for 1 cycle -> next cycle busy_o=0, mem_req=0, done_o=0; the late mem_done is ignored; the next req_i=3'b111 grants requester 0.
